// File: rtl/leglite_pkg.sv
// leglite_pkg: opcode, ALU select, state encodings and control-word type shared by the LEGLite control path and datapath
// Contents: OP_* opcode constants, ALU_* function codes, state_t FSM encoding,
//           ctrl_t bundle of datapath enables, is_rtype() helper.
package leglite_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ORR  = 3'd3;
  localparam logic [2:0] OP_LDUR = 3'd4;
  localparam logic [2:0] OP_STUR = 3'd5;
  localparam logic [2:0] OP_CBZ  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;
  typedef struct packed {
    logic       ir_write;
    logic       pc_inc;
    logic       pc_branch;
    logic       ab_load;
    logic       reg2loc;
    logic       alusrc;
    logic [2:0] alu_select;
    logic       aluout_load;
    logic       dread;
    logic       dwrite;
    logic       mdr_load;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
  } ctrl_t;
  // R-type opcodes double as their ALU function code
  function automatic logic is_rtype(input logic [2:0] op);
    return op <= OP_ORR;
  endfunction
endpackage

// File: rtl/leglite_multicycle_ctrl_if.sv
// leglite_multicycle_ctrl_if: control/status bundle between the LEGLite sequencer and its datapath
// master: sequencer side (receives opcode, alu_zero, imem_ready, dmem_ready; drives enables, selects, state)
// slave:  datapath side (the reverse directions)
interface leglite_multicycle_ctrl_if;
  logic [2:0] opcode;
  logic       alu_zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       ir_write;
  logic       pc_inc;
  logic       pc_branch;
  logic       ab_load;
  logic       reg2loc;
  logic       alusrc;
  logic [2:0] alu_select;
  logic       aluout_load;
  logic       dread;
  logic       dwrite;
  logic       mdr_load;
  logic       memtoreg;
  logic       regwrite;
  logic       instr_done;
  logic [2:0] state;
  modport master (
    input  opcode, alu_zero, imem_ready, dmem_ready,
    output ir_write, pc_inc, pc_branch, ab_load, reg2loc, alusrc, alu_select,
           aluout_load, dread, dwrite, mdr_load, memtoreg, regwrite, instr_done, state
  );
  modport slave (
    output opcode, alu_zero, imem_ready, dmem_ready,
    input  ir_write, pc_inc, pc_branch, ab_load, reg2loc, alusrc, alu_select,
           aluout_load, dread, dwrite, mdr_load, memtoreg, regwrite, instr_done, state
  );
endinterface

// File: rtl/leglite_perf_counters.sv
// leglite_perf_counters: saturating cycle and retired-instruction counters (built only with LEGLITE_PERF_COUNT_EN)
// Ports: clock, reset (sync, active-high), instr_done in; cycle_count[15:0], instr_count[15:0] out.
`ifdef LEGLITE_PERF_COUNT_EN
module leglite_perf_counters (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_done,
  output logic [15:0] cycle_count,
  output logic [15:0] instr_count
);
  logic [15:0] cycle_q, cycle_d, instr_q, instr_d;
  always_comb begin
    cycle_d = (cycle_q == 16'hFFFF) ? cycle_q : cycle_q + 16'd1;
    instr_d = (instr_done && instr_q != 16'hFFFF) ? instr_q + 16'd1 : instr_q;
  end
  always_ff @(posedge clock) begin
    cycle_q <= reset ? 16'd0 : cycle_d;
    instr_q <= reset ? 16'd0 : instr_d;
  end
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
endmodule
`endif

// File: rtl/leglite_multicycle_ctrl.sv
// leglite_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the multicycle LEGLite datapath
// Ports: clock, reset (sync, active-high); bus (leglite_multicycle_ctrl_if.master) carrying
//        opcode/alu_zero/imem_ready/dmem_ready in and all datapath enables, selects and state out.
// Optional: LEGLITE_PERF_COUNT_EN adds cycle_count[15:0] and instr_count[15:0] outputs.
module leglite_multicycle_ctrl
  import leglite_pkg::*;
(
  input  logic clock,
  input  logic reset,
  leglite_multicycle_ctrl_if.master bus
`ifdef LEGLITE_PERF_COUNT_EN
  ,
  output logic [15:0] cycle_count,
  output logic [15:0] instr_count
`endif
);
  logic [2:0] state_q, state_d;
  ctrl_t dec, out;
  always_ff @(posedge clock) state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    dec = '0;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        dec.ir_write = bus.imem_ready;
        dec.pc_inc = bus.imem_ready;
        state_d = bus.imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        dec.ab_load = 1'b1;
        dec.reg2loc = bus.opcode inside {OP_STUR, OP_CBZ};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.opcode == OP_CBZ) begin
          dec.alu_select = ALU_PASSB;
          dec.pc_branch = bus.alu_zero;
          dec.instr_done = 1'b1;
          state_d = S_FETCH;
        end else begin
          dec.alu_select = is_rtype(bus.opcode) ? bus.opcode : ALU_ADD;
          dec.alusrc = !is_rtype(bus.opcode);
          dec.aluout_load = 1'b1;
          state_d = (bus.opcode inside {OP_LDUR, OP_STUR}) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        // the request stays up and ALU-out (the address) is untouched until dmem_ready
        dec.dread = bus.opcode == OP_LDUR;
        dec.dwrite = bus.opcode == OP_STUR;
        dec.mdr_load = dec.dread & bus.dmem_ready;
        dec.instr_done = dec.dwrite & bus.dmem_ready;
        state_d = !(dec.dread | dec.dwrite) ? S_FETCH :
                  !bus.dmem_ready ? S_MEM :
                  dec.dread ? S_WB : S_FETCH;
      end
      S_WB: begin
        dec.regwrite = 1'b1;
        dec.memtoreg = bus.opcode == OP_LDUR;
        dec.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
  // reset silences every output in the same cycle, so an abandoned access never commits
  assign out = reset ? '0 : dec;
  assign bus.state = reset ? 3'd0 : state_q;
  assign bus.ir_write = out.ir_write;
  assign bus.pc_inc = out.pc_inc;
  assign bus.pc_branch = out.pc_branch;
  assign bus.ab_load = out.ab_load;
  assign bus.reg2loc = out.reg2loc;
  assign bus.alusrc = out.alusrc;
  assign bus.alu_select = out.alu_select;
  assign bus.aluout_load = out.aluout_load;
  assign bus.dread = out.dread;
  assign bus.dwrite = out.dwrite;
  assign bus.mdr_load = out.mdr_load;
  assign bus.memtoreg = out.memtoreg;
  assign bus.regwrite = out.regwrite;
  assign bus.instr_done = out.instr_done;
`ifdef LEGLITE_PERF_COUNT_EN
  leglite_perf_counters u_perf (
    .clock(clock),
    .reset(reset),
    .instr_done(out.instr_done),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );
`endif
endmodule

// File: tb/tb_leglite_multicycle_ctrl.sv
// tb_leglite_multicycle_ctrl: directed self-checking bench for leglite_multicycle_ctrl
module tb_leglite_multicycle_ctrl;
  import leglite_pkg::*;
  localparam logic [15:0] IRW = 16'h8000, PCI = 16'h4000, PCB = 16'h2000, ABL = 16'h1000;
  localparam logic [15:0] R2L = 16'h0800, ASRC = 16'h0400, AOL = 16'h0040, DRD = 16'h0020;
  localparam logic [15:0] DWR = 16'h0010, MDR = 16'h0008, M2R = 16'h0004, RGW = 16'h0002, DONE = 16'h0001;
  localparam logic [15:0] SEL_SUB = 16'h0080, SEL_AND = 16'h0100, SEL_OR = 16'h0180, SEL_PASSB = 16'h0200;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  leglite_multicycle_ctrl_if bus ();
`ifdef LEGLITE_PERF_COUNT_EN
  logic [15:0] cycle_count, instr_count;
`endif
  leglite_multicycle_ctrl dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef LEGLITE_PERF_COUNT_EN
    ,
    .cycle_count(cycle_count),
    .instr_count(instr_count)
`endif
  );
  always #5 clock = ~clock;
  logic [18:0] obs;
  assign obs = {bus.state, bus.ir_write, bus.pc_inc, bus.pc_branch, bus.ab_load, bus.reg2loc,
                bus.alusrc, bus.alu_select, bus.aluout_load, bus.dread, bus.dwrite, bus.mdr_load,
                bus.memtoreg, bus.regwrite, bus.instr_done};
  function automatic logic [18:0] ev(input logic [2:0] s, input logic [15:0] f);
    return {s, f};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    bus.opcode = OP_ADD;
    bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    tests++;
    if (obs !== 19'd0) begin
      failed++;
      $display("FAIL reset_outputs: got %h want %h", obs, 19'd0);
    end
    tick();
    reset = 1'b0;
  endtask
  task automatic test_add();
    logic [18:0] e [4];
    e = '{ev(0, IRW | PCI), ev(1, ABL), ev(2, AOL), ev(4, RGW | DONE)};
    bus.opcode = OP_ADD;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL add cyc%0d: got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask
  task automatic test_alu_ops();
    logic [2:0] ops [4];
    logic [15:0] ex [4];
    logic [18:0] e [4];
    ops = '{OP_SUB, OP_AND, OP_ORR, OP_ADDI};
    ex = '{AOL | SEL_SUB, AOL | SEL_AND, AOL | SEL_OR, AOL | ASRC};
    for (int k = 0; k < 4; k++) begin
      e = '{ev(0, IRW | PCI), ev(1, ABL), ev(2, ex[k]), ev(4, RGW | DONE)};
      bus.opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clock);
        tests++;
        if (obs !== e[i]) begin
          failed++;
          $display("FAIL alu_op%0d cyc%0d: got %h want %h", ops[k], i, obs, e[i]);
        end
        tick();
      end
    end
  endtask
  task automatic test_ldur_stall();
    logic [18:0] e [7];
    bit im [7];
    bit dm [7];
    e = '{ev(0, IRW | PCI), ev(1, ABL), ev(2, AOL | ASRC), ev(3, DRD), ev(3, DRD),
          ev(3, DRD | MDR), ev(4, M2R | RGW | DONE)};
    im = '{1, 0, 0, 0, 0, 0, 0};
    dm = '{1, 1, 1, 0, 0, 1, 0};
    bus.opcode = OP_LDUR;
    for (int i = 0; i < 7; i++) begin
      bus.imem_ready = im[i];
      bus.dmem_ready = dm[i];
      @(negedge clock);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL ldur cyc%0d: got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask
  task automatic test_cbz();
    logic [18:0] e [3];
    bus.opcode = OP_CBZ;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      e = '{ev(0, IRW | PCI), ev(1, ABL | R2L), ev(2, SEL_PASSB | DONE | (z == 1 ? PCB : 16'h0))};
      bus.alu_zero = (z == 1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        tests++;
        if (obs !== e[i]) begin
          failed++;
          $display("FAIL cbz_z%0d cyc%0d: got %h want %h", z, i, obs, e[i]);
        end
        tick();
      end
    end
    bus.alu_zero = 1'b0;
  endtask
  task automatic test_stur_fetch_stall();
    logic [18:0] e [5];
    bit im [5];
    e = '{ev(0, 16'h0), ev(0, IRW | PCI), ev(1, ABL | R2L), ev(2, AOL | ASRC), ev(3, DWR | DONE)};
    im = '{0, 1, 0, 0, 0};
    bus.opcode = OP_STUR;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.imem_ready = im[i];
      @(negedge clock);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL stur cyc%0d: got %h want %h", i, obs, e[i]);
      end
      tick();
    end
  endtask
  task automatic test_reset_mid_mem();
    logic [18:0] e [6];
    bit rs [6];
    bit dm [6];
    e = '{ev(0, IRW | PCI), ev(1, ABL | R2L), ev(2, AOL | ASRC), ev(3, DWR), 19'd0, ev(0, IRW | PCI)};
    rs = '{0, 0, 0, 0, 1, 0};
    dm = '{1, 1, 1, 0, 1, 1};
    bus.opcode = OP_STUR;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reset = rs[i];
      bus.dmem_ready = dm[i];
      @(negedge clock);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs, e[i]);
      end
      tick();
    end
    reset = 1'b0;
  endtask
`ifdef LEGLITE_PERF_COUNT_EN
  task automatic test_perf();
    bus.opcode = OP_ADD;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    reset = 1'b1;
    tick();
    tests++;
    if (cycle_count !== 16'd0 || instr_count !== 16'd0) begin
      failed++;
      $display("FAIL perf_reset: got %h/%h want 0000/0000", cycle_count, instr_count);
    end
    reset = 1'b0;
    repeat (40) tick();
    tests++;
    if (cycle_count !== 16'd40 || instr_count !== 16'd10) begin
      failed++;
      $display("FAIL perf_10_adds: got %0d/%0d want 40/10", cycle_count, instr_count);
    end
    bus.imem_ready = 1'b0;
    repeat (65495) tick();
    tests++;
    if (cycle_count !== 16'hFFFF) begin
      failed++;
      $display("FAIL perf_reach_sat: got %h want ffff", cycle_count);
    end
    repeat (3) tick();
    tests++;
    if (cycle_count !== 16'hFFFF || instr_count !== 16'd10) begin
      failed++;
      $display("FAIL perf_hold_sat: got %h/%0d want ffff/10", cycle_count, instr_count);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_ldur_stall();
    test_cbz();
    test_stur_fetch_stall();
    test_reset_mid_mem();
`ifdef LEGLITE_PERF_COUNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
